// File: rtl/fp16_pkg.sv
// Shared binary16 types, constants and rounding helpers for the FP datapath.
package fp16_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } roundmode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    // Normalised operand: 11-bit mantissa with hidden bit at [10], exponent
    // held as 8-bit two's complement so subnormals can go below 1.
    typedef struct packed {
        logic [7:0]  exp;
        logic [10:0] mant;
    } norm_t;

    localparam int unsigned BIAS = 15;
    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;
    localparam logic [15:0] MAXF = 16'h7BFF;

    // Bring a finite operand to 1.xxx form; subnormals shift by leading-zero count.
    function automatic norm_t fp16_norm(input fp16_t x);
        norm_t      n;
        logic [3:0] sh;
        sh = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (x.frac[i]) sh = 4'(10 - i);
        end
        if (x.exp == 5'd0) begin
            n.exp  = 8'd1 - {4'd0, sh};
            n.mant = {1'b0, x.frac} << sh;
        end else begin
            n.exp  = {3'd0, x.exp};
            n.mant = {1'b1, x.frac};
        end
        return n;
    endfunction

    // Increment decision for one rounding step; rest = round | sticky.
    function automatic logic round_up(input roundmode_e mode, input logic sign,
                                      input logic lsb, input logic guard,
                                      input logic rest);
        case (mode)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (guard | rest);
            RM_RUP:  return ~sign & (guard | rest);
            RM_RMM:  return guard;
            default: return guard & (rest | lsb);
        endcase
    endfunction

    // Whether an overflow saturates to infinity (else to max finite).
    function automatic logic ovf_to_inf(input roundmode_e mode, input logic sign);
        case (mode)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign;
            RM_RUP:  return ~sign;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fp16_round.sv
// Combinational binary16 rounder: denormalises, rounds, packs and flags.
module fp16_round
    import fp16_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [7:0] exp_i,
    input  logic [10:0]       mant_i,
    input  logic              guard_i,
    input  logic              round_i,
    input  logic              sticky_i,
    input  roundmode_e        mode_i,
    output logic [15:0]       result_c_o,
    output logic              of_c_o,
    output logic              uf_c_o,
    output logic              nx_c_o
);

    logic              tiny_pre;
    logic signed [8:0] shdiff;
    logic [3:0]        shamt;
    logic [26:0]       wide;
    logic [10:0]       m2;
    logic              g2;
    logic              rs;
    logic              inexact;
    logic              inc;
    logic              full_inc;
    logic              tiny;
    logic              ovf;
    logic [4:0]        ebase;
    logic [14:0]       sum;

    // Shift into subnormal range, round, and detect overflow/tininess.
    always_comb begin
        tiny_pre = (exp_i <= 8'sd0);
        shdiff   = 9'sd1 - {exp_i[7], exp_i};
        shamt    = 4'd0;
        if (tiny_pre) shamt = (shdiff > 9'sd14) ? 4'd14 : shdiff[3:0];
        wide     = {mant_i, guard_i, round_i, 14'd0} >> shamt;
        m2       = wide[26:16];
        g2       = wide[15];
        rs       = (|wide[14:0]) | sticky_i;
        inexact  = g2 | rs;
        inc      = round_up(mode_i, sign_i, m2[0], g2, rs);
        // Hidden bit is added back through m2, so normals use exponent-1 as base.
        ebase    = tiny_pre ? 5'd0 : 5'(exp_i - 8'sd1);
        sum      = {ebase, 10'd0} + 15'(m2) + 15'(inc);
        ovf      = (exp_i > 8'sd30) | (sum[14:10] == 5'h1F);
        // Tininess after rounding: only a 0x7FF mantissa at exponent 0 can escape.
        full_inc = round_up(mode_i, sign_i, mant_i[0], guard_i, round_i | sticky_i);
        tiny     = tiny_pre & ~((exp_i == 8'sd0) & (mant_i == 11'h7FF) & full_inc);

        result_c_o = {sign_i, sum};
        of_c_o     = 1'b0;
        uf_c_o     = tiny & inexact;
        nx_c_o     = inexact;
        if (ovf) begin
            result_c_o = ovf_to_inf(mode_i, sign_i) ? {sign_i, 15'(PINF)}
                                                    : {sign_i, 15'(MAXF)};
            of_c_o     = 1'b1;
            uf_c_o     = 1'b0;
            nx_c_o     = 1'b1;
        end
    end

endmodule

// File: rtl/fp16_div_seq.sv
// Iterative binary16 divider, one restoring quotient bit per cycle.
module fp16_div_seq
    import fp16_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] operands_i,
    input  logic [2:0]  rnd_mode_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] result_o,
    output logic [4:0]  status_o
);

    localparam int unsigned QBITS = 13;
    localparam int unsigned CW    = 4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UNPACK = 3'd1;
    localparam logic [2:0] DIV    = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    fp16_t             a_q, a_d, b_q, b_d;
    roundmode_e        rnd_q, rnd_d;
    logic              sign_q, sign_d;
    logic signed [7:0] exp_q, exp_d;
    logic [10:0]       mb_q, mb_d;
    logic [11:0]       rem_q, rem_d;
    logic [12:0]       quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              spec_q, spec_d;
    logic [15:0]       spec_res_q, spec_res_d;
    status_t           spec_st_q, spec_st_d;
    logic [15:0]       res_q, res_d;
    status_t           st_q, st_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    norm_t             na, nb;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic              is_spec;
    logic [15:0]       sp_res;
    status_t           sp_st;
    logic              sp_sign;

    logic signed [7:0] r_exp;
    logic [10:0]       r_mant;
    logic              r_g, r_r;
    logic [15:0]       r_res;
    logic              r_of, r_uf, r_nx;

    logic              div_ge;
    logic [11:0]       div_diff;

    // Operand classification and forced results for special operands.
    always_comb begin
        na      = fp16_norm(a_q);
        nb      = fp16_norm(b_q);
        a_zero  = (a_q.exp == 5'd0)  && (a_q.frac == 10'd0);
        a_inf   = (a_q.exp == 5'h1F) && (a_q.frac == 10'd0);
        a_nan   = (a_q.exp == 5'h1F) && (a_q.frac != 10'd0);
        b_zero  = (b_q.exp == 5'd0)  && (b_q.frac == 10'd0);
        b_inf   = (b_q.exp == 5'h1F) && (b_q.frac == 10'd0);
        b_nan   = (b_q.exp == 5'h1F) && (b_q.frac != 10'd0);
        sp_sign = a_q.sign ^ b_q.sign;
        is_spec = 1'b1;
        sp_res  = QNAN;
        sp_st   = '0;
        if (a_nan || b_nan) begin
            sp_st.nv = (a_nan & ~a_q.frac[9]) | (b_nan & ~b_q.frac[9]);
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_st.nv = 1'b1;
        end else if (a_inf) begin
            sp_res = {sp_sign, 15'(PINF)};
        end else if (b_inf) begin
            sp_res = {sp_sign, 15'd0};
        end else if (b_zero) begin
            sp_res   = {sp_sign, 15'(PINF)};
            sp_st.dz = 1'b1;
        end else if (a_zero) begin
            sp_res = {sp_sign, 15'd0};
        end else begin
            is_spec = 1'b0;
        end
    end

    // Realign the quotient so the leading one sits at the hidden-bit position.
    always_comb begin
        if (quo_q[12]) begin
            r_exp  = exp_q;
            r_mant = quo_q[12:2];
            r_g    = quo_q[1];
            r_r    = quo_q[0];
        end else begin
            r_exp  = exp_q - 8'sd1;
            r_mant = quo_q[11:1];
            r_g    = quo_q[0];
            r_r    = 1'b0;
        end
    end

    fp16_round u_round (
        .sign_i     (sign_q),
        .exp_i      (r_exp),
        .mant_i     (r_mant),
        .guard_i    (r_g),
        .round_i    (r_r),
        .sticky_i   (|rem_q),
        .mode_i     (rnd_q),
        .result_c_o (r_res),
        .of_c_o     (r_of),
        .uf_c_o     (r_uf),
        .nx_c_o     (r_nx)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rnd_d      = rnd_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mb_d       = mb_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_st_d  = spec_st_q;
        res_d      = res_q;
        st_d       = st_q;
        div_ge     = (rem_q >= {1'b0, mb_q});
        div_diff   = div_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = fp16_t'(operands_i[31:16]);
                    b_d     = fp16_t'(operands_i[15:0]);
                    rnd_d   = (rnd_mode_i > 3'd4) ? RM_RNE : roundmode_e'(rnd_mode_i);
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d     = sp_sign;
                exp_d      = na.exp - nb.exp + 8'(BIAS);
                mb_d       = nb.mant;
                rem_d      = {1'b0, na.mant};
                quo_d      = '0;
                cnt_d      = '0;
                spec_d     = is_spec;
                spec_res_d = sp_res;
                spec_st_d  = sp_st;
                state_d    = is_spec ? ROUND : DIV;
            end
            DIV: begin
                quo_d = {quo_q[11:0], div_ge};
                rem_d = div_diff << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(QBITS - 1)) state_d = ROUND;
            end
            ROUND: begin
                if (spec_q) begin
                    res_d = spec_res_q;
                    st_d  = spec_st_q;
                end else begin
                    res_d = r_res;
                    st_d  = '{nv: 1'b0, dz: 1'b0, of: r_of, uf: r_uf, nx: r_nx};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rnd_q       <= RM_RNE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mb_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            spec_st_q   <= '0;
            res_q       <= '0;
            st_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rnd_q       <= rnd_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mb_q        <= mb_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            spec_q      <= spec_d;
            spec_res_q  <= spec_res_d;
            spec_st_q   <= spec_st_d;
            res_q       <= res_d;
            st_q        <= st_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = res_q;
    assign status_o    = st_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed testbench for fp16_div_seq with hand-computed quotients and flags.
module tb_fp16_div_seq;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] operands_i;
    logic [2:0]  rnd_mode_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] result_o;
    logic [4:0]  status_o;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_NX   = 5'b00001;
    localparam logic [4:0] S_UFNX = 5'b00011;
    localparam logic [4:0] S_OFNX = 5'b00101;
    localparam logic [4:0] S_DZ   = 5'b01000;
    localparam logic [4:0] S_NV   = 5'b10000;

    fp16_div_seq dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operands_i  (operands_i),
        .rnd_mode_i  (rnd_mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .status_o    (status_o)
    );

    always #5 clk = ~clk;

    // Issue one operation, wait (bounded) for the result, then consume it.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                         output logic [15:0] r, output logic [4:0] s, output int lat);
        @(negedge clk);
        operands_i = {a, b};
        rnd_mode_i = m;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result_o;
        s = status_o;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        operands_i  = '0;
        rnd_mode_i  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
        checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h exp=0000", result_o); end
        checks++; if (status_o !== 5'b0) begin errors++; $display("FAIL reset_status got=%b exp=00000", status_o); end
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] r; logic [4:0] s; int lat;
        do_op(16'h4000, 16'h4000, 3'd0, r, s, lat);
        checks++; if (r !== 16'h3C00) begin errors++; $display("FAIL basic_result got=%h exp=3c00", r); end
        checks++; if (s !== S_NONE) begin errors++; $display("FAIL basic_status got=%b exp=%b", s, S_NONE); end
        checks++; if (lat != 15) begin errors++; $display("FAIL basic_latency got=%0d exp=15", lat); end
    endtask

    task automatic test_round_modes();
        logic [2:0]  md [5] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd7};
        logic [15:0] er [5] = '{16'h3555, 16'h3556, 16'h3555, 16'h3555, 16'h3555};
        logic [15:0] r; logic [4:0] s; int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(16'h3C00, 16'h4200, md[i], r, s, lat);
            checks++; if (r !== er[i]) begin errors++; $display("FAIL third_result mode=%0d got=%h exp=%h", md[i], r, er[i]); end
            checks++; if (s !== S_NX) begin errors++; $display("FAIL third_status mode=%0d got=%b exp=%b", md[i], s, S_NX); end
        end
    endtask

    task automatic test_specials();
        logic [15:0] ta [7] = '{16'h3C00, 16'h0000, 16'h7D00, 16'h7E01, 16'hFC00, 16'h3C00, 16'h8000};
        logic [15:0] tb [7] = '{16'h0000, 16'h0000, 16'h3C00, 16'h3C00, 16'h4000, 16'h7C00, 16'h4000};
        logic [15:0] er [7] = '{16'h7C00, 16'h7E00, 16'h7E00, 16'h7E00, 16'hFC00, 16'h0000, 16'h8000};
        logic [4:0]  es [7] = '{S_DZ, S_NV, S_NV, S_NONE, S_NONE, S_NONE, S_NONE};
        logic [15:0] r; logic [4:0] s; int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], 3'd0, r, s, lat);
            checks++; if (r !== er[i]) begin errors++; $display("FAIL special_result idx=%0d got=%h exp=%h", i, r, er[i]); end
            checks++; if (s !== es[i]) begin errors++; $display("FAIL special_status idx=%0d got=%b exp=%b", i, s, es[i]); end
            checks++; if (lat != 2) begin errors++; $display("FAIL special_latency idx=%0d got=%0d exp=2", i, lat); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] ta [4] = '{16'h7BFF, 16'h7BFF, 16'hFBFF, 16'hFBFF};
        logic [2:0]  md [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [15:0] er [4] = '{16'h7C00, 16'h7BFF, 16'hFC00, 16'hFBFF};
        logic [15:0] r; logic [4:0] s; int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], 16'h3800, md[i], r, s, lat);
            checks++; if (r !== er[i]) begin errors++; $display("FAIL ovf_result idx=%0d got=%h exp=%h", i, r, er[i]); end
            checks++; if (s !== S_OFNX) begin errors++; $display("FAIL ovf_status idx=%0d got=%b exp=%b", i, s, S_OFNX); end
        end
    endtask

    task automatic test_subnormal();
        logic [15:0] ta [4] = '{16'h0400, 16'h0001, 16'h0001, 16'h0001};
        logic [15:0] tb [4] = '{16'h4400, 16'h4000, 16'h4000, 16'h3800};
        logic [2:0]  md [4] = '{3'd0, 3'd0, 3'd3, 3'd0};
        logic [15:0] er [4] = '{16'h0100, 16'h0000, 16'h0001, 16'h0002};
        logic [4:0]  es [4] = '{S_NONE, S_UFNX, S_UFNX, S_NONE};
        logic [15:0] r; logic [4:0] s; int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], md[i], r, s, lat);
            checks++; if (r !== er[i]) begin errors++; $display("FAIL sub_result idx=%0d got=%h exp=%h", i, r, er[i]); end
            checks++; if (s !== es[i]) begin errors++; $display("FAIL sub_status idx=%0d got=%b exp=%b", i, s, es[i]); end
            checks++; if (lat != 15) begin errors++; $display("FAIL sub_latency idx=%0d got=%0d exp=15", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        operands_i = {16'h4500, 16'h4000};
        rnd_mode_i = 3'd0;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 15) begin errors++; $display("FAIL bp_latency got=%0d exp=15", n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid_o); end
            checks++; if (result_o !== 16'h4100) begin errors++; $display("FAIL bp_result cyc=%0d got=%h exp=4100", i, result_o); end
            checks++; if (status_o !== S_NONE) begin errors++; $display("FAIL bp_status cyc=%0d got=%b exp=00000", i, status_o); end
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready_o); end
            @(posedge clk);
            #1;
        end
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready_o); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r; logic [4:0] s; int lat;
        @(negedge clk);
        operands_i = {16'h4000, 16'h4000};
        rnd_mode_i = 3'd0;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", in_ready_o); end
        @(negedge clk);
        rst_i = 1'b0;
        do_op(16'h3C00, 16'h4200, 3'd0, r, s, lat);
        checks++; if (r !== 16'h3555) begin errors++; $display("FAIL midrst_result got=%h exp=3555", r); end
        checks++; if (s !== S_NX) begin errors++; $display("FAIL midrst_status got=%b exp=%b", s, S_NX); end
        checks++; if (lat != 15) begin errors++; $display("FAIL midrst_latency got=%0d exp=15", lat); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r; logic [4:0] s; int lat;
        do_op(16'h4000, 16'h3C00, 3'd0, r, s, lat);
        checks++; if (r !== 16'h4000) begin errors++; $display("FAIL b2b_first got=%h exp=4000", r); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid got=%b exp=0", out_valid_o); end
        do_op(16'hC500, 16'h4000, 3'd0, r, s, lat);
        checks++; if (r !== 16'hC100) begin errors++; $display("FAIL b2b_second got=%h exp=c100", r); end
        checks++; if (s !== S_NONE) begin errors++; $display("FAIL b2b_status got=%b exp=00000", s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_modes();
        test_specials();
        test_overflow();
        test_subnormal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
